// File: rtl/csi_lane_aligner.sv
// csi_lane_aligner: merges the HS byte streams of up to NUM_LANES D-PHY lanes
// into one word per byte clock. Every lane has a small deskew FIFO, so lanes
// that start a few bytes late are lined up before a word is emitted. At the
// tail of a packet, lanes that finish early are flagged through lane_strb_o.
//
// Handshake: lane_valid_o is a one-cycle qualifier with no ready. Every cycle
// in which it is high carries a merged word that the consumer must take.
// lane_strb_o marks which byte lanes of lane_data_o are present. Bytes whose
// strobe is low are always 0x00.
module csi_lane_aligner #(
  parameter int NUM_LANES  = 4,
  parameter int SKEW_DEPTH = 4
) (
  input  logic                         rx_byte_clk_hs_i,
  input  logic                         reset_i,
  input  logic [$clog2(NUM_LANES):0]   active_lanes_i,
  input  logic [NUM_LANES-1:0]         rx_valid_hs_i,
  input  logic [8*NUM_LANES-1:0]       rx_data_hs_i,
  output logic                         lane_valid_o,
  output logic [8*NUM_LANES-1:0]       lane_data_o,
  output logic [NUM_LANES-1:0]         lane_strb_o,
  output logic                         skew_err_o,
  output logic                         busy_o
);

  localparam int AW = $clog2(NUM_LANES) + 1;
  localparam int PW = $clog2(SKEW_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  // control state
  state_e                 state_q, state_d;
  logic [AW-1:0]          n_q, n_d;
  logic [CW-1:0]          align_cnt_q, align_cnt_d;
  logic                   restart_q, restart_d;

  // per-lane FIFOs
  logic [7:0]             mem_q [NUM_LANES][SKEW_DEPTH];
  logic [7:0]             mem_d [NUM_LANES][SKEW_DEPTH];
  logic [PW-1:0]          wr_q  [NUM_LANES];
  logic [PW-1:0]          wr_d  [NUM_LANES];
  logic [PW-1:0]          rd_q  [NUM_LANES];
  logic [PW-1:0]          rd_d  [NUM_LANES];
  logic [CW-1:0]          cnt_q [NUM_LANES];
  logic [CW-1:0]          cnt_d [NUM_LANES];
  logic [CW-1:0]          cnt_nxt [NUM_LANES];

  // registered outputs
  logic                   valid_q, valid_d;
  logic [8*NUM_LANES-1:0] data_q, data_d;
  logic [NUM_LANES-1:0]   strb_q, strb_d;
  logic                   skew_err_q, skew_err_d;

  // combinational helpers
  logic [AW-1:0]          n_clamp;
  logic [AW-1:0]          n_eff;
  logic [NUM_LANES-1:0]   act;
  logic [NUM_LANES-1:0]   nonempty;
  logic [NUM_LANES-1:0]   full;
  logic [NUM_LANES-1:0]   push;
  logic [NUM_LANES-1:0]   pop;
  logic                   any_valid;
  logic                   all_ready;
  logic                   overflow;
  logic                   drained;
  logic                   err;

  // Clamp the requested lane count. The live input only matters while
  // IDLE; once a packet has started, the held copy is used.
  always_comb begin
    n_clamp = active_lanes_i;
    if (active_lanes_i == '0) begin
      n_clamp = AW'(1);
    end else if (active_lanes_i > AW'(NUM_LANES)) begin
      n_clamp = AW'(NUM_LANES);
    end
    n_eff = (state_q == S_IDLE) ? n_clamp : n_q;
    act      = '0;
    nonempty = '0;
    full     = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      act[k]      = (AW'(k) < n_eff);
      nonempty[k] = (cnt_q[k] != '0);
      full[k]     = (cnt_q[k] == CW'(SKEW_DEPTH));
    end
  end

  // Push/pop decisions. Words form only when every active lane holds a byte,
  // except in DRAIN, where whatever is left in each lane is flushed out.
  always_comb begin
    push = act & rx_valid_hs_i;
    if (state_q == S_ERR) begin
      push = '0;
    end
    any_valid = |(act & rx_valid_hs_i);
    all_ready = &(nonempty | ~act);
    overflow  = |(push & full);
    pop       = '0;
    case (state_q)
      S_ALIGN, S_STREAM: pop = all_ready ? act : '0;
      S_DRAIN:           pop = nonempty & act;
      default:           pop = '0;
    endcase
    drained = 1'b1;
    for (int k = 0; k < NUM_LANES; k++) begin
      cnt_nxt[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      if (cnt_nxt[k] != '0) begin
        drained = 1'b0;
      end
    end
  end

  // Packet FSM. Any error flushes the FIFOs and parks the block in ERR
  // until the active lanes go quiet.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    align_cnt_d = align_cnt_q;
    restart_d   = restart_q;
    err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        n_d         = n_clamp;
        align_cnt_d = '0;
        restart_d   = 1'b0;
        if (any_valid) begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (|pop) begin
          state_d = S_STREAM;
        end else begin
          align_cnt_d = align_cnt_q + CW'(1);
          if (align_cnt_d == CW'(SKEW_DEPTH)) begin
            err = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (!any_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        align_cnt_d = '0;
        if (any_valid) begin
          restart_d = 1'b1;
        end
        if (drained) begin
          state_d   = restart_q ? S_ALIGN : S_IDLE;
          restart_d = 1'b0;
        end
      end
      S_ERR: begin
        if (!any_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (overflow) begin
      err = 1'b1;
    end
    if (err) begin
      state_d     = S_ERR;
      align_cnt_d = '0;
      restart_d   = 1'b0;
    end
  end

  // FIFO storage and pointers. A flush rewinds the pointers and drops the
  // byte that caused the error.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      wr_d[k]  = wr_q[k];
      rd_d[k]  = rd_q[k];
      cnt_d[k] = cnt_nxt[k];
      if (push[k]) begin
        mem_d[k][wr_q[k]] = rx_data_hs_i[8*k +: 8];
        wr_d[k]           = wr_q[k] + PW'(1);
      end
      if (pop[k]) begin
        rd_d[k] = rd_q[k] + PW'(1);
      end
      if (err) begin
        wr_d[k]  = '0;
        rd_d[k]  = '0;
        cnt_d[k] = '0;
      end
    end
  end

  // Output word: popped bytes with their strobes, zero when nothing pops.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (pop[k]) begin
        data_d[8*k +: 8] = mem_q[k][rd_q[k]];
      end
    end
    strb_d  = pop;
    valid_d = |pop;
    if (err) begin
      data_d  = '0;
      strb_d  = '0;
      valid_d = 1'b0;
    end
    skew_err_d = err;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge rx_byte_clk_hs_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      n_q         <= AW'(NUM_LANES);
      align_cnt_q <= '0;
      restart_q   <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      strb_q      <= '0;
      skew_err_q  <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      align_cnt_q <= align_cnt_d;
      restart_q   <= restart_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      skew_err_q  <= skew_err_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        wr_q[k]  <= wr_d[k];
        rd_q[k]  <= rd_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // FIFO byte storage needs no reset: contents are only read when counted.
  always_ff @(posedge rx_byte_clk_hs_i) begin
    mem_q <= mem_d;
  end

  assign lane_valid_o = valid_q;
  assign lane_data_o  = data_q;
  assign lane_strb_o  = strb_q;
  assign skew_err_o   = skew_err_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: doc/csi_lane_aligner.md
CSI_LANE_ALIGNER -- requirements
Module: csi_lane_aligner

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of physical D-PHY HS lanes (legal 1..8).
REQ-002 SHALL have parameter SKEW_DEPTH, default 4, per-lane deskew FIFO depth in bytes (power of 2, >=2).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port rx_byte_clk_hs_i, input, width 1: the single byte clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, width 1: synchronous reset, active-high.
REQ-006 SHALL have port active_lanes_i, input, width $clog2(NUM_LANES)+1: runtime lane count.
REQ-007 SHALL have port rx_valid_hs_i, input, width NUM_LANES: per-lane HS byte valid; bit k is lane k.
REQ-008 SHALL have port rx_data_hs_i, input, width 8*NUM_LANES: lane k byte on bits [8k+7:8k].
REQ-009 SHALL have port lane_valid_o, output, width 1: the merged word is valid this cycle.
REQ-010 SHALL have port lane_data_o, output, width 8*NUM_LANES: merged, deskewed bytes in the same lane order.
REQ-011 SHALL have port lane_strb_o, output, width NUM_LANES: per-lane byte-present mask qualifying lane_data_o.
REQ-012 SHALL have port skew_err_o, output, width 1: one-cycle pulse on skew or overflow error.
REQ-013 SHALL have port busy_o, output, width 1: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ALIGN, STREAM, DRAIN and ERR.
REQ-015 SHALL sample active_lanes_i only in IDLE and hold the value as N until the next IDLE; 0 is treated as 1 and values above NUM_LANES as NUM_LANES.
REQ-016 SHALL treat lanes 0..N-1 as active and ignore the valid and data inputs of all other lanes.
REQ-017 SHALL provide one FIFO per lane, SKEW_DEPTH deep; on every edge where an active lane has rx_valid_hs_i high and the state is not ERR, its byte is pushed.
REQ-018 IDLE->ALIGN SHALL occur on the edge where any active lane valid is high; that byte is pushed on the same edge.
REQ-019 A "pop" SHALL occur on any edge in ALIGN or STREAM where all active FIFOs are non-empty: one byte is popped from every active FIFO.
REQ-020 On a pop, lane_data_o SHALL be registered with the popped bytes, lane_strb_o with the active mask, and lane_valid_o=1; output latency is therefore one edge after all lanes hold their byte.
REQ-021 ALIGN->STREAM SHALL occur on the first pop.
REQ-022 ALIGN SHALL count cycles in which some active FIFO is empty; when the count reaches SKEW_DEPTH, the block SHALL pulse skew_err_o, flush all FIFOs and go to ERR.
REQ-023 In any state, a push into a full FIFO SHALL pulse skew_err_o, flush all FIFOs and go to ERR; the overflowing byte is dropped.
REQ-024 STREAM->DRAIN SHALL occur on the edge where all active valids are low.
REQ-025 DRAIN SHALL pop every non-empty active FIFO each cycle.
REQ-026 In DRAIN, lane_strb_o bit k SHALL be 1 only if lane k popped, and lane_data_o bytes with strobe 0 SHALL be 0x00.
REQ-027 DRAIN->IDLE SHALL occur when all FIFOs are empty after the pop.
REQ-028 In DRAIN, a new valid on any active lane SHALL be pushed and SHALL NOT change state until the FIFOs empty; the block then returns to ALIGN, not IDLE.
REQ-029 ERR SHALL hold lane_valid_o=0 and push nothing.
REQ-030 ERR->IDLE SHALL occur on the first edge where all active valids are low.
REQ-031 lane_valid_o SHALL be 0 on every edge without a pop; lane_data_o and lane_strb_o SHALL then be 0.
REQ-032 There is no backpressure; the downstream SHALL accept every lane_valid_o cycle.

Reset
REQ-033 While reset_i=1 on an edge, the block SHALL enter IDLE, empty all FIFOs, clear the ALIGN counter and set N=NUM_LANES.
REQ-034 While reset_i=1 on an edge, all outputs SHALL be 0.
REQ-035 A reset asserted mid-packet SHALL discard all buffered bytes with no error pulse.

Verification
REQ-036 Aligned: N=4, all lanes valid together for 3 bytes (0x10..0x13, 0x20..0x23, 0x30..0x33) -> 3 consecutive lane_valid_o cycles, first one edge after the first input edge, strb=4'hF, data matching, then IDLE.
REQ-037 Skew: lane 2 lags by 2 cycles, SKEW_DEPTH=4 -> output starts 2 cycles later than aligned, bytes correctly lane-matched, no skew_err_o.
REQ-038 Excess skew: lane 3 never goes valid, SKEW_DEPTH=4 -> skew_err_o single pulse 4 cycles into ALIGN, no lane_valid_o, IDLE once all valids are low.
REQ-039 Uneven tail: lanes 0-1 send 5 bytes, lanes 2-3 send 4 bytes -> 4 words with strb=4'hF, then 1 word with strb=4'h3 and bytes 2-3 equal to 0x00.
REQ-040 Reduced lanes: active_lanes_i=2 with lanes 2-3 toggling garbage -> strb=4'h3 and upper bytes 0.
REQ-041 Reset mid-STREAM: reset_i asserted for 1 cycle -> all outputs 0 next cycle, busy_o=0, and the next packet is aligned normally.
